// File: rtl/hazard_control_pkg.sv
// Shared definitions for the issue-stage hazard controller: FSM states,
// parameter defaults and a register-index decoder.
package hazard_control_pkg;

  localparam int unsigned MaxInflightDefault = 3;
  localparam int unsigned FlushCyclesDefault = 2;
  localparam int unsigned NumRegs            = 16;

  typedef enum logic [0:0] {
    HcRun,
    HcFlush
  } hc_state_e;

  function automatic logic [NumRegs-1:0] onehot16(input logic en, input logic [3:0] idx);
    logic [NumRegs-1:0] oh;
    oh      = '0;
    oh[idx] = en;
    return oh;
  endfunction

endpackage

// File: rtl/hazard_control_if.sv
// Issue / retire / cancel / jump bundle between the pipeline and the hazard controller.
interface hazard_control_if;

  logic        issue_valid;
  logic        issue_read_a_en;
  logic [3:0]  issue_read_a_index;
  logic        issue_read_b_en;
  logic [3:0]  issue_read_b_index;
  logic        issue_write_en;
  logic [3:0]  issue_write_index;
  logic        issue_reads_flags;
  logic        issue_writes_flags;
  logic        retire_write;
  logic [3:0]  retire_index;
  logic        retire_flags;
  logic        cancel_write;
  logic [3:0]  cancel_index;
  logic        cancel_flags;
  logic        jump;

  logic        issue_accept;
  logic        stall;
  logic        flush;
  logic [15:0] pending_mask;
  logic        flags_pending;
  logic        underflow_err;

  modport slave (
    input  issue_valid, issue_read_a_en, issue_read_a_index, issue_read_b_en,
           issue_read_b_index, issue_write_en, issue_write_index, issue_reads_flags,
           issue_writes_flags, retire_write, retire_index, retire_flags, cancel_write,
           cancel_index, cancel_flags, jump,
    output issue_accept, stall, flush, pending_mask, flags_pending, underflow_err
  );

  modport master (
    output issue_valid, issue_read_a_en, issue_read_a_index, issue_read_b_en,
           issue_read_b_index, issue_write_en, issue_write_index, issue_reads_flags,
           issue_writes_flags, retire_write, retire_index, retire_flags, cancel_write,
           cancel_index, cancel_flags, jump,
    input  issue_accept, stall, flush, pending_mask, flags_pending, underflow_err
  );

endinterface

// File: rtl/hazard_counter.sv
// Saturating in-flight counter: +inc, -dec per cycle, clamped to 0..MAX_INFLIGHT.
// underflow flags a decrement that would have gone below zero.
module hazard_counter
  import hazard_control_pkg::*;
#(
  parameter int unsigned MAX_INFLIGHT = MaxInflightDefault
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       inc,
  input  logic [1:0] dec,
  output logic [1:0] count,
  output logic       underflow
);

  localparam logic [2:0] MaxCount = 3'(MAX_INFLIGHT);

  logic [1:0] count_q, count_d;
  logic [2:0] avail, diff;

  always_comb begin
    avail     = {1'b0, count_q} + {2'b00, inc};
    diff      = avail - {1'b0, dec};
    underflow = avail < {1'b0, dec};
    if (underflow) begin
      count_d = '0;
    end else if (diff > MaxCount) begin
      count_d = MaxCount[1:0];
    end else begin
      count_d = diff[1:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_control.sv
// Scoreboard-style issue interlock: per-register and flags in-flight counters gate issue,
// and a small FSM squashes younger fetches for FLUSH_CYCLES after a taken jump.
module hazard_control
  import hazard_control_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = FlushCyclesDefault,
  parameter int unsigned MAX_INFLIGHT = MaxInflightDefault
) (
  input logic             clock,
  input logic             reset,
  hazard_control_if.slave bus
);

  localparam int unsigned     FcW       = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FcW-1:0]  FlushLoad = FcW'(FLUSH_CYCLES - 1);
  localparam logic [1:0]      MaxCount  = 2'(MAX_INFLIGHT);

  hc_state_e          state_q, state_d;
  logic [FcW-1:0]     flush_cnt_q, flush_cnt_d;
  logic               underflow_q;

  logic [1:0]         reg_count [NumRegs];
  logic [NumRegs-1:0] reg_uf;
  logic [NumRegs-1:0] pending;
  logic [NumRegs-1:0] inc_oh, ret_oh, can_oh;
  logic [1:0]         flags_count;
  logic               flags_uf;
  logic               accept;

  // Hazards are judged on registered counts only, so a same-cycle retire never bypasses.
  always_comb begin
    accept = bus.issue_valid && (state_q == HcRun);
    if (bus.issue_read_a_en && (reg_count[bus.issue_read_a_index] != 2'd0)) accept = 1'b0;
    if (bus.issue_read_b_en && (reg_count[bus.issue_read_b_index] != 2'd0)) accept = 1'b0;
    if (bus.issue_reads_flags && (flags_count != 2'd0)) accept = 1'b0;
    if (bus.issue_write_en && (reg_count[bus.issue_write_index] == MaxCount)) accept = 1'b0;
    if (bus.issue_writes_flags && (flags_count == MaxCount)) accept = 1'b0;
  end

  assign inc_oh = onehot16(accept && bus.issue_write_en, bus.issue_write_index);
  assign ret_oh = onehot16(bus.retire_write, bus.retire_index);
  assign can_oh = onehot16(bus.cancel_write, bus.cancel_index);

  for (genvar n = 0; n < NumRegs; n++) begin : g_reg
    hazard_counter #(
      .MAX_INFLIGHT(MAX_INFLIGHT)
    ) u_cnt (
      .clock     (clock),
      .reset     (reset),
      .inc       (inc_oh[n]),
      .dec       ({ret_oh[n] & can_oh[n], ret_oh[n] ^ can_oh[n]}),
      .count     (reg_count[n]),
      .underflow (reg_uf[n])
    );
    assign pending[n] = |reg_count[n];
  end

  hazard_counter #(
    .MAX_INFLIGHT(MAX_INFLIGHT)
  ) u_flags_cnt (
    .clock     (clock),
    .reset     (reset),
    .inc       (accept && bus.issue_writes_flags),
    .dec       ({bus.retire_flags & bus.cancel_flags, bus.retire_flags ^ bus.cancel_flags}),
    .count     (flags_count),
    .underflow (flags_uf)
  );

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    unique case (state_q)
      HcRun: begin
        if (bus.jump) begin
          state_d     = HcFlush;
          flush_cnt_d = FlushLoad;
        end
      end
      HcFlush: begin
        // A jump while flushing restarts the full flush window.
        if (bus.jump) begin
          flush_cnt_d = FlushLoad;
        end else if (flush_cnt_q == '0) begin
          state_d = HcRun;
        end else begin
          flush_cnt_d = flush_cnt_q - FcW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= HcRun;
      flush_cnt_q <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      underflow_q <= underflow_q | (|reg_uf) | flags_uf;
    end
  end

  assign bus.issue_accept  = accept;
  assign bus.stall         = bus.issue_valid & ~accept;
  assign bus.flush         = (state_q == HcFlush);
  assign bus.pending_mask  = pending;
  assign bus.flags_pending = |flags_count;
  assign bus.underflow_err = underflow_q;

endmodule

// File: tb/tb_hazard_control.sv
// Directed-vector bench for hazard_control: the driver queues the expected output
// vector for each cycle and a negedge monitor pops and compares it.
module tb_hazard_control;

  logic clock = 1'b0;
  logic reset;

  hazard_control_if hc ();

  hazard_control dut (
    .clock (clock),
    .reset (reset),
    .bus   (hc)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        chk;
    logic [20:0] exp;  // {accept, stall, flush, pending_mask, flags_pending, underflow_err}
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, got no end, required end of vectors");
    $fatal(1);
  end

  // Monitor: one queued expectation per cycle, sampled mid-cycle.
  always @(negedge clock) begin
    if (q.size() != 0) begin
      exp_t        e;
      logic [20:0] act;
      e   = q.pop_front();
      act = {hc.issue_accept, hc.stall, hc.flush, hc.pending_mask, hc.flags_pending,
             hc.underflow_err};
      if (e.chk) begin
        n_total++;
        if (act === e.exp) n_pass++;
        else $display("FAIL %s: got acc=%b stall=%b flush=%b mask=%h fp=%b uf=%b, expected acc=%b stall=%b flush=%b mask=%h fp=%b uf=%b",
                      e.name, act[20], act[19], act[18], act[17:2], act[1], act[0],
                      e.exp[20], e.exp[19], e.exp[18], e.exp[17:2], e.exp[1], e.exp[0]);
      end
    end
  end

  task automatic clr();
    reset                 = 1'b0;
    hc.issue_valid        = 1'b0;
    hc.issue_read_a_en    = 1'b0;
    hc.issue_read_a_index = '0;
    hc.issue_read_b_en    = 1'b0;
    hc.issue_read_b_index = '0;
    hc.issue_write_en     = 1'b0;
    hc.issue_write_index  = '0;
    hc.issue_reads_flags  = 1'b0;
    hc.issue_writes_flags = 1'b0;
    hc.retire_write       = 1'b0;
    hc.retire_index       = '0;
    hc.retire_flags       = 1'b0;
    hc.cancel_write       = 1'b0;
    hc.cancel_index       = '0;
    hc.cancel_flags       = 1'b0;
    hc.jump               = 1'b0;
  endtask

  task automatic iss(input logic ra_en, input logic [3:0] ra, input logic rb_en,
                     input logic [3:0] rb, input logic w_en, input logic [3:0] w,
                     input logic rf, input logic wf);
    hc.issue_valid        = 1'b1;
    hc.issue_read_a_en    = ra_en;
    hc.issue_read_a_index = ra;
    hc.issue_read_b_en    = rb_en;
    hc.issue_read_b_index = rb;
    hc.issue_write_en     = w_en;
    hc.issue_write_index  = w;
    hc.issue_reads_flags  = rf;
    hc.issue_writes_flags = wf;
  endtask

  task automatic wr(input logic [3:0] w);
    iss(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, w, 1'b0, 1'b0);
  endtask

  task automatic ret(input logic [3:0] idx);
    hc.retire_write = 1'b1;
    hc.retire_index = idx;
  endtask

  // Queue this cycle's expectation, advance one clock, return inputs to idle.
  task automatic tick(input string name, input logic chk, input logic acc, input logic fl,
                      input logic [15:0] mask, input logic fp, input logic uf);
    exp_t e;
    e.chk  = chk;
    e.exp  = {acc, hc.issue_valid & ~acc, fl, mask, fp, uf};
    e.name = name;
    q.push_back(e);
    @(posedge clock);
    #1;
    clr();
  endtask

  initial begin
    clr();
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Reset overrides issue, jump and a cancel on an empty counter.
    clr(); reset = 1'b1; wr(4'd4); hc.jump = 1'b1; hc.cancel_write = 1'b1; hc.cancel_index = 4'd7;
    tick("reset_state",   1, 1, 0, 16'h0000, 0, 0);
    hc.issue_valid = 1'b1;
    tick("reset_release", 1, 1, 0, 16'h0000, 0, 0);

    // RAW on r3 after an ALU op writing r3 and flags.
    iss(0, 0, 0, 0, 1, 4'd3, 0, 1);
    tick("r3_issue",      1, 1, 0, 16'h0000, 0, 0);
    iss(0, 0, 1, 4'd3, 1, 4'd6, 0, 0);
    tick("r3_raw_stall",  1, 0, 0, 16'h0008, 1, 0);
    iss(0, 0, 1, 4'd3, 1, 4'd6, 0, 0); ret(4'd3);
    tick("r3_no_bypass",  1, 0, 0, 16'h0008, 1, 0);
    iss(0, 0, 1, 4'd3, 1, 4'd6, 0, 0);
    tick("r3_accept",     1, 1, 0, 16'h0000, 1, 0);
    ret(4'd6); hc.retire_flags = 1'b1;
    tick("r6_retire",     1, 0, 0, 16'h0040, 1, 0);
    tick("clean1",        1, 0, 0, 16'h0000, 0, 0);

    // Write limit on r5.
    wr(4'd5); tick("r5_w1",         1, 1, 0, 16'h0000, 0, 0);
    wr(4'd5); tick("r5_w2",         1, 1, 0, 16'h0020, 0, 0);
    wr(4'd5); tick("r5_w3",         1, 1, 0, 16'h0020, 0, 0);
    wr(4'd5); tick("r5_full",       1, 0, 0, 16'h0020, 0, 0);
    wr(4'd5); ret(4'd5);
    tick("r5_full_ret",   1, 0, 0, 16'h0020, 0, 0);
    wr(4'd5); tick("r5_w4",         1, 1, 0, 16'h0020, 0, 0);
    wr(4'd5); tick("r5_full_again", 1, 0, 0, 16'h0020, 0, 0);
    ret(4'd5); tick("r5_drain1",    0, 0, 0, 16'h0020, 0, 0);
    ret(4'd5); tick("r5_drain2",    0, 0, 0, 16'h0020, 0, 0);
    ret(4'd5); tick("r5_drain3",    1, 0, 0, 16'h0020, 0, 0);
    tick("r5_empty",      1, 0, 0, 16'h0000, 0, 0);

    // Same-cycle increment and decrement on r2 nets to no change.
    wr(4'd2); tick("r2_w",          1, 1, 0, 16'h0000, 0, 0);
    wr(4'd2); ret(4'd2);
    tick("r2_w_ret",      1, 1, 0, 16'h0004, 0, 0);
    tick("r2_count1",     1, 0, 0, 16'h0004, 0, 0);
    ret(4'd2); tick("r2_drain",     0, 0, 0, 16'h0004, 0, 0);
    tick("r2_empty",      1, 0, 0, 16'h0000, 0, 0);

    // Self-overwrite is not a hazard; a later reader of r1 is.
    iss(1, 4'd1, 0, 0, 1, 4'd1, 0, 0);
    tick("self_ovw",      1, 1, 0, 16'h0000, 0, 0);
    iss(1, 4'd1, 0, 0, 1, 4'd4, 0, 0);
    tick("r1_raw_a",      1, 0, 0, 16'h0002, 0, 0);
    ret(4'd1); tick("r1_drain",     0, 0, 0, 16'h0002, 0, 0);
    tick("r1_empty",      1, 0, 0, 16'h0000, 0, 0);

    // Single jump: two flush cycles.
    hc.issue_valid = 1'b1; hc.jump = 1'b1;
    tick("jump",          1, 1, 0, 16'h0000, 0, 0);
    hc.issue_valid = 1'b1; tick("flush1",    1, 0, 1, 16'h0000, 0, 0);
    hc.issue_valid = 1'b1; tick("flush2",    1, 0, 1, 16'h0000, 0, 0);
    hc.issue_valid = 1'b1; tick("flush_end", 1, 1, 0, 16'h0000, 0, 0);

    // Jump in first flush cycle extends to three; retire still processed in FLUSH.
    wr(4'd8); tick("r8_w",          1, 1, 0, 16'h0000, 0, 0);
    hc.jump = 1'b1; tick("jump2",   1, 0, 0, 16'h0100, 0, 0);
    hc.issue_valid = 1'b1; hc.jump = 1'b1; ret(4'd8);
    tick("ext_flush1",    1, 0, 1, 16'h0100, 0, 0);
    hc.issue_valid = 1'b1; tick("ext_flush2", 1, 0, 1, 16'h0000, 0, 0);
    tick("ext_flush3",    1, 0, 1, 16'h0000, 0, 0);
    hc.issue_valid = 1'b1; tick("ext_end",    1, 1, 0, 16'h0000, 0, 0);

    // Flags dependency, then underflow on an empty register.
    iss(0, 0, 0, 0, 0, 0, 0, 1); tick("alu_flags",    1, 1, 0, 16'h0000, 0, 0);
    iss(0, 0, 0, 0, 0, 0, 1, 0); tick("br_stall",     1, 0, 0, 16'h0000, 1, 0);
    iss(0, 0, 0, 0, 0, 0, 1, 0); hc.retire_flags = 1'b1;
    tick("br_no_bypass",  1, 0, 0, 16'h0000, 1, 0);
    iss(0, 0, 0, 0, 0, 0, 1, 0); tick("br_accept",    1, 1, 0, 16'h0000, 0, 0);
    hc.cancel_write = 1'b1; hc.cancel_index = 4'd7;
    tick("cancel_zero",   1, 0, 0, 16'h0000, 0, 0);
    tick("uf_set",        1, 0, 0, 16'h0000, 0, 1);
    tick("uf_sticky",     1, 0, 0, 16'h0000, 0, 1);

    // Reset in the middle of a flush with r1 and r9 pending.
    wr(4'd1); tick("r1_w",          1, 1, 0, 16'h0000, 0, 1);
    wr(4'd9); tick("r9_w",          1, 1, 0, 16'h0002, 0, 1);
    hc.jump = 1'b1; tick("jump3",   1, 0, 0, 16'h0202, 0, 1);
    reset = 1'b1; wr(4'd4); hc.jump = 1'b1;
    tick("reset_mid_flush", 1, 0, 1, 16'h0202, 0, 1);
    iss(1, 4'd1, 1, 4'd9, 0, 0, 0, 0);
    tick("post_reset",    1, 1, 0, 16'h0000, 0, 0);
    tick("post_reset_idle", 1, 0, 0, 16'h0000, 0, 0);

    @(negedge clock);
    #1;
    if (q.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
